// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC engine: FSM state encoding and named generator polynomials.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } crc_state_t;

  // Generator polynomials without the implicit top term
  localparam logic [15:0] CRC16_CDMA2000 = 16'hC867;
  localparam logic [15:0] CRC16_XMODEM   = 16'h1021;

endpackage

// File: rtl/crc_step.sv
// Combinational CRC update: folds DATA_W data bits, MSB first, into the register in one pass.
module crc_step
  import crc_pkg::*;
#(
  parameter int               CRC_W  = 16,
  parameter int               DATA_W = 8,
  parameter logic [CRC_W-1:0] POLY   = CRC16_CDMA2000
) (
  input  logic [CRC_W-1:0]  cur_reg,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  next_reg
);

  // Unrolled serial LFSR: each iteration is one bit-time of the classic shift/XOR register
  always_comb begin
    next_reg = cur_reg;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (next_reg[CRC_W-1] ^ data[i])
        next_reg = {next_reg[CRC_W-2:0], 1'b0} ^ POLY;
      else
        next_reg = {next_reg[CRC_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/crc_engine.sv
// Streaming CRC engine with valid/ready input beats and a held result handshake.
// Optional macro CRC_CHECK_EN adds CHECK_RESIDUE and the CRC_OK residue comparator.
module crc_engine
  import crc_pkg::*;
#(
  parameter int               CRC_W   = 16,
  parameter int               DATA_W  = 8,
  parameter logic [CRC_W-1:0] POLY    = CRC16_CDMA2000,
  parameter logic [CRC_W-1:0] INIT    = 16'hFFFF,
  parameter logic [CRC_W-1:0] XOR_OUT = '0
`ifdef CRC_CHECK_EN
  ,
  parameter logic [CRC_W-1:0] CHECK_RESIDUE = '0
`endif
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CLEAR,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  input  logic [DATA_W-1:0] DIN_DATA,
  input  logic              DIN_LAST,
  output logic              CRC_VALID,
  input  logic              CRC_READY,
  output logic [CRC_W-1:0]  CRC_DATA
`ifdef CRC_CHECK_EN
  ,
  output logic              CRC_OK
`endif
);

  crc_state_t       state;
  logic [CRC_W-1:0] crc_reg;
  logic [CRC_W-1:0] next_reg;
  logic             beat_accept;

  assign beat_accept = DIN_VALID && DIN_READY;

  crc_step #(
    .CRC_W  (CRC_W),
    .DATA_W (DATA_W),
    .POLY   (POLY)
  ) u_step (
    .cur_reg  (crc_reg),
    .data     (DIN_DATA),
    .next_reg (next_reg)
  );

  // DIN_READY is registered so it stays low through reset and rises on the first edge after it.
  // CLEAR outranks both a simultaneous beat and CRC_READY.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      crc_reg   <= INIT;
      CRC_VALID <= 1'b0;
      CRC_DATA  <= '0;
      DIN_READY <= 1'b0;
    end else if (CLEAR) begin
      state     <= IDLE;
      crc_reg   <= INIT;
      CRC_VALID <= 1'b0;
      CRC_DATA  <= '0;
      DIN_READY <= 1'b1;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          DIN_READY <= 1'b1;
          if (beat_accept) begin
            crc_reg <= next_reg;
            if (DIN_LAST) begin
              state     <= DONE;
              CRC_VALID <= 1'b1;
              CRC_DATA  <= next_reg ^ XOR_OUT;
              DIN_READY <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        DONE: begin
          if (CRC_READY) begin
            state     <= IDLE;
            crc_reg   <= INIT;
            CRC_VALID <= 1'b0;
            CRC_DATA  <= '0;
            DIN_READY <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          crc_reg   <= INIT;
          CRC_VALID <= 1'b0;
          CRC_DATA  <= '0;
          DIN_READY <= 1'b1;
        end
      endcase
    end
  end

`ifdef CRC_CHECK_EN
  assign CRC_OK = CRC_VALID && (CRC_DATA == CHECK_RESIDUE);
`endif

endmodule

// File: tb/tb_crc_engine.sv
// Self-checking bench for crc_engine: default, XMODEM and 1-bit-serial instances against a long-division CRC model.
module tb_crc_engine;

  typedef logic [7:0] byte_q_t[$];

  logic        CLK;
  logic        RESET;
  logic        CLEAR;
  logic        DIN_VALID;
  logic [7:0]  DIN_DATA;
  logic        DIN_LAST;
  logic        CRC_READY;

  logic        din_ready, crc_valid;
  logic [15:0] crc_data;
  logic        x_din_ready, x_crc_valid;
  logic [15:0] x_crc_data;

  logic        s_valid, s_data, s_last, s_crc_ready;
  logic        s_din_ready, s_crc_valid;
  logic [15:0] s_crc_data;
`ifdef CRC_CHECK_EN
  logic        crc_ok, x_crc_ok, s_crc_ok;
`endif

  int assert_count = 0;
  int fail_count   = 0;

  crc_engine dut (
    .CLK (CLK), .RESET (RESET), .CLEAR (CLEAR),
    .DIN_VALID (DIN_VALID), .DIN_READY (din_ready), .DIN_DATA (DIN_DATA), .DIN_LAST (DIN_LAST),
    .CRC_VALID (crc_valid), .CRC_READY (CRC_READY), .CRC_DATA (crc_data)
`ifdef CRC_CHECK_EN
    , .CRC_OK (crc_ok)
`endif
  );

  crc_engine #(.POLY (16'h1021), .INIT (16'h0000)) dut_x (
    .CLK (CLK), .RESET (RESET), .CLEAR (CLEAR),
    .DIN_VALID (DIN_VALID), .DIN_READY (x_din_ready), .DIN_DATA (DIN_DATA), .DIN_LAST (DIN_LAST),
    .CRC_VALID (x_crc_valid), .CRC_READY (CRC_READY), .CRC_DATA (x_crc_data)
`ifdef CRC_CHECK_EN
    , .CRC_OK (x_crc_ok)
`endif
  );

  crc_engine #(.DATA_W (1)) dut_s (
    .CLK (CLK), .RESET (RESET), .CLEAR (CLEAR),
    .DIN_VALID (s_valid), .DIN_READY (s_din_ready), .DIN_DATA (s_data), .DIN_LAST (s_last),
    .CRC_VALID (s_crc_valid), .CRC_READY (s_crc_ready), .CRC_DATA (s_crc_data)
`ifdef CRC_CHECK_EN
    , .CRC_OK (s_crc_ok)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // CRC as polynomial long division: init XORed onto the first 16 message bits, 16 zero bits appended
  function automatic logic [15:0] crcModel(input byte_q_t msg, input logic [15:0] poly, input logic [15:0] init);
    bit q[$];
    int n;
    logic [15:0] r;
    n = msg.size() * 8;
    for (int i = 0; i < n + 16; i++) q.push_back(1'b0);
    for (int k = 0; k < n; k++) q[k] = msg[k / 8][7 - (k % 8)];
    for (int j = 0; j < 16; j++) q[j] = q[j] ^ init[15 - j];
    for (int i = 0; i < n; i++) begin
      if (q[i]) begin
        q[i] = 1'b0;
        for (int k = 1; k <= 16; k++) q[i + k] = q[i + k] ^ poly[16 - k];
      end
    end
    for (int j = 0; j < 16; j++) r[15 - j] = q[n + j];
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic last);
    int waited;
    waited = 0;
    DIN_VALID = 1'b1;
    DIN_DATA  = data;
    DIN_LAST  = last;
    while (!din_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!din_ready) checkOutput("din_ready_timeout", {31'b0, din_ready}, 32'd1);
    tick();
    DIN_VALID = 1'b0;
    DIN_LAST  = 1'b0;
  endtask

  task automatic sendFrame(input byte_q_t msg, input bit gaps);
    foreach (msg[i]) begin
      if (gaps) repeat ($urandom_range(0, 1)) tick();
      applyStimulus(msg[i], i == msg.size() - 1);
    end
  endtask

  task automatic checkFrame(input string tag, input byte_q_t msg);
    logic [15:0] exp_c, exp_x;
    exp_c = crcModel(msg, 16'hC867, 16'hFFFF);
    exp_x = crcModel(msg, 16'h1021, 16'h0000);
    checkOutput({tag, "_valid"}, {31'b0, crc_valid}, 32'd1);
    checkOutput({tag, "_crc"}, {16'b0, crc_data}, {16'b0, exp_c});
    checkOutput({tag, "_xcrc"}, {16'b0, x_crc_data}, {16'b0, exp_x});
`ifdef CRC_CHECK_EN
    checkOutput({tag, "_ok"}, {31'b0, crc_ok}, {31'b0, exp_c == 16'h0});
    checkOutput({tag, "_xok"}, {31'b0, x_crc_ok}, {31'b0, exp_x == 16'h0});
`endif
  endtask

  task automatic consumeResult(input int hold);
    CRC_READY = 1'b0;
    repeat (hold) tick();
    CRC_READY = 1'b1;
    tick();
    CRC_READY = 1'b0;
    checkOutput("consume_valid", {31'b0, crc_valid}, 32'd0);
    checkOutput("consume_data", {16'b0, crc_data}, 32'd0);
  endtask

  initial begin
    byte_q_t digits, msg;
    for (int i = 0; i < 9; i++) digits.push_back(8'h31 + 8'(i));

    RESET = 1'b1; CLEAR = 1'b0; DIN_VALID = 1'b0; DIN_DATA = '0; DIN_LAST = 1'b0; CRC_READY = 1'b0;
    s_valid = 1'b0; s_data = 1'b0; s_last = 1'b0; s_crc_ready = 1'b0;

    // Reset values and DIN_READY rising only on the first edge after release
    repeat (2) tick();
    checkOutput("rst_ready", {31'b0, din_ready}, 32'd0);
    checkOutput("rst_valid", {31'b0, crc_valid}, 32'd0);
    checkOutput("rst_data", {16'b0, crc_data}, 32'd0);
    RESET = 1'b0;
    #2;
    checkOutput("rel_ready_before_edge", {31'b0, din_ready}, 32'd0);
    tick();
    checkOutput("rel_ready_after_edge", {31'b0, din_ready}, 32'd1);

    // Check string, then five cycles of backpressure with a beat waiting
    sendFrame(digits, 1'b0);
    checkOutput("check_valid", {31'b0, crc_valid}, 32'd1);
    checkOutput("check_cdma", {16'b0, crc_data}, 32'h4C06);
    checkOutput("check_xmodem", {16'b0, x_crc_data}, 32'h31C3);
    DIN_VALID = 1'b1; DIN_DATA = 8'hA5; DIN_LAST = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("bp_valid", {31'b0, crc_valid}, 32'd1);
      checkOutput("bp_data", {16'b0, crc_data}, 32'h4C06);
      checkOutput("bp_ready", {31'b0, din_ready}, 32'd0);
    end
    CRC_READY = 1'b1;
    tick();
    CRC_READY = 1'b0; DIN_VALID = 1'b0; DIN_LAST = 1'b0;
    checkOutput("bp_release_valid", {31'b0, crc_valid}, 32'd0);
    checkOutput("bp_release_ready", {31'b0, din_ready}, 32'd1);
    sendFrame(digits, 1'b0);
    checkOutput("after_bp_cdma", {16'b0, crc_data}, 32'h4C06);
    consumeResult(0);

    // Appended CRC gives a zero residue; a flipped bit breaks it
    msg = digits;
    msg.push_back(8'h4C); msg.push_back(8'h06);
    sendFrame(msg, 1'b0);
    checkOutput("residue_zero", {16'b0, crc_data}, 32'd0);
    checkFrame("residue", msg);
    consumeResult(2);
    msg[3] = msg[3] ^ 8'h01;
    sendFrame(msg, 1'b0);
    checkFrame("corrupt", msg);
    consumeResult(1);

    // CLEAR mid-frame, colliding with a last beat that must be dropped
    for (int i = 0; i < 4; i++) applyStimulus(digits[i], 1'b0);
    CLEAR = 1'b1; DIN_VALID = 1'b1; DIN_DATA = 8'h55; DIN_LAST = 1'b1;
    tick();
    CLEAR = 1'b0; DIN_VALID = 1'b0; DIN_LAST = 1'b0;
    checkOutput("clear_valid", {31'b0, crc_valid}, 32'd0);
    checkOutput("clear_ready", {31'b0, din_ready}, 32'd1);
    sendFrame(digits, 1'b0);
    checkOutput("after_clear_cdma", {16'b0, crc_data}, 32'h4C06);

    // CLEAR while a result is held, together with CRC_READY
    CLEAR = 1'b1; CRC_READY = 1'b1;
    tick();
    CLEAR = 1'b0; CRC_READY = 1'b0;
    checkOutput("clear_done_valid", {31'b0, crc_valid}, 32'd0);
    checkOutput("clear_done_data", {16'b0, crc_data}, 32'd0);

    // Single-beat frame
    msg = {};
    msg.push_back(8'h41);
    sendFrame(msg, 1'b0);
    checkFrame("single", msg);
    consumeResult(0);

    // Reset mid-frame: immediate clear of outputs and no result for the partial frame
    for (int i = 0; i < 3; i++) applyStimulus(digits[i], 1'b0);
    RESET = 1'b1;
    #1;
    checkOutput("midrst_ready", {31'b0, din_ready}, 32'd0);
    checkOutput("midrst_valid", {31'b0, crc_valid}, 32'd0);
    #3;
    RESET = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("midrst_no_result", {31'b0, crc_valid}, 32'd0);
    end
    sendFrame(digits, 1'b0);
    checkOutput("after_rst_cdma", {16'b0, crc_data}, 32'h4C06);
    consumeResult(0);

    // Random frames with random gaps and result hold times
    for (int f = 0; f < 10; f++) begin
      int len;
      len = $urandom_range(1, 7);
      msg = {};
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
      sendFrame(msg, 1'b1);
      checkFrame("random", msg);
      consumeResult($urandom_range(0, 3));
    end

    // One-bit-wide engine fed the check string serially
    for (int k = 0; k < 72; k++) begin
      int w;
      w = 0;
      s_valid = 1'b1;
      s_data  = digits[k / 8][7 - (k % 8)];
      s_last  = (k == 71);
      while (!s_din_ready && w < 20) begin
        tick();
        w++;
      end
      if (!s_din_ready) checkOutput("serial_ready_timeout", {31'b0, s_din_ready}, 32'd1);
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    checkOutput("serial_valid", {31'b0, s_crc_valid}, 32'd1);
    checkOutput("serial_cdma", {16'b0, s_crc_data}, 32'h4C06);
`ifdef CRC_CHECK_EN
    checkOutput("serial_ok", {31'b0, s_crc_ok}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
